// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among REQS requesters.
// The character is latched at grant time, written with a WR_HOLD-cycle strobe,
// and the arbiter then waits for buffempty to fall and recover before the next
// grant. A buffempty that never falls is flagged as a sticky timeout.
//
// state       | meaning
// S_IDLE      | waiting for en, a request and an empty uart buffer
// S_LOAD      | character latched on uart_data, one setup cycle
// S_WRITE     | uart_wr high for WR_HOLD cycles, ack on the last one
// S_WAIT_LOW  | waiting for buffempty to fall, guarded by the timeout
// S_WAIT_HIGH | waiting for buffempty to return, then record last grant
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int REQS    = 4,
  parameter int DATA_W  = 9,
  parameter int WR_HOLD = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [REQS-1:0]        i_req,
  input  logic [REQS*DATA_W-1:0] i_data_in,
  output logic [REQS-1:0]        o_ack,
  output logic [2:0]             o_grant_id,
  output logic                   o_busy,
  output logic                   o_err,
  input  logic                   i_err_clr,
  output logic [DATA_W-1:0]      o_uart_data,
  output logic                   o_uart_wr,
  input  logic                   i_uart_buffempty
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_WAIT_LOW, S_WAIT_HIGH
  } state_t;

  state_t            r_state, w_next;
  logic              r_be_meta, r_be_s;
  logic [3:0]        r_hold;
  logic [15:0]       r_tmo;
  logic [2:0]        r_grant_id, r_last, w_pick;
  logic              w_found, w_grant, w_hold_last, w_timeout;
  logic [DATA_W-1:0] r_uart_data, w_char;
  logic              r_err;
  logic [REQS-1:0]   w_ack;
  logic              w_wr, w_busy;

  // buffempty comes from uart_clk; reset to 1 so a fresh arbiter sees an idle uart
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_be_meta <= 1'b1;
      r_be_s    <= 1'b1;
    end else begin
      r_be_meta <= i_uart_buffempty;
      r_be_s    <= r_be_meta;
    end
  end

  // round-robin search starting one past the last completed grant
  always_comb begin
    int              w_idx;
    logic [REQS-1:0] w_sh;
    w_idx   = 0;
    w_sh    = '0;
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = 1; k <= REQS; k++) begin
      w_idx = (int'(r_last) + k) % REQS;
      w_sh  = i_req >> w_idx;
      if (!w_found && w_sh[0]) begin
        w_found = 1'b1;
        w_pick  = 3'(w_idx);
      end
    end
    w_char = DATA_W'(i_data_in >> (int'(w_pick) * DATA_W));
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state and decoded outputs
  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_timeout   = 1'b0;
    w_wr        = 1'b0;
    w_ack       = '0;
    w_busy      = (r_state != S_IDLE);
    w_hold_last = (r_hold == 4'(WR_HOLD - 1));
    case (r_state)
      S_IDLE: begin
        if (i_en && w_found && r_be_s) begin
          w_grant = 1'b1;
          w_next  = S_LOAD;
        end
      end
      S_LOAD: w_next = S_WRITE;
      S_WRITE: begin
        w_wr = 1'b1;
        if (w_hold_last) begin
          w_ack  = REQS'(1) << r_grant_id;
          w_next = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!r_be_s) begin
          w_next = S_WAIT_HIGH;
        end else if (r_tmo == 16'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        if (r_be_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // character and grant captured only at grant, so uart_data holds through the write
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_uart_data <= '0;
      r_grant_id  <= 3'(REQS - 1);
      r_last      <= 3'(REQS - 1);
    end else begin
      if (w_grant) begin
        r_uart_data <= w_char;
        r_grant_id  <= w_pick;
      end
      if (r_state == S_WAIT_HIGH && r_be_s) r_last <= r_grant_id;
    end
  end

  // write-hold and buffempty timeout counters, cleared outside their states
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hold <= '0;
      r_tmo  <= '0;
    end else begin
      r_hold <= (r_state == S_WRITE) ? r_hold + 4'd1 : 4'd0;
      r_tmo  <= (r_state == S_WAIT_LOW && r_be_s) ? r_tmo + 16'd1 : 16'd0;
    end
  end

  // sticky timeout flag; a timeout in the same cycle as a clear keeps it set
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)         r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
    else if (i_err_clr) r_err <= 1'b0;
  end

  assign o_ack       = w_ack;
  assign o_grant_id  = r_grant_id;
  assign o_busy      = w_busy;
  assign o_err       = r_err;
  assign o_uart_data = r_uart_data;
  assign o_uart_wr   = w_wr;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter REQS, default 4, number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter DATA_W, default 9, character width matching uart_tx data.
REQ-003 Parameter WR_HOLD, default 2, clk cycles uart_wr is held high (1..15).
REQ-004 Parameter TIMEOUT, default 255, clk cycles allowed for uart_buffempty to drop after a write (1..65535).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock; all state updates on posedge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 en  input  1  high = new grants allowed; low = finish current transfer, no new grants.
REQ-009 req  input  REQS  per-requester transmit request, level, held until own ack.
REQ-010 data_in  input  REQS*DATA_W  requester i character in bits [i*DATA_W +: DATA_W], stable while req[i] high.
REQ-011 ack  output  REQS  one-cycle pulse to granted requester when its character is written.
REQ-012 grant_id  output  3  index of current/last granted requester.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  sticky timeout flag.
REQ-015 err_clr  input  1  synchronous clear of err.
REQ-016 uart_data  output  DATA_W  character presented to uart_tx data.
REQ-017 uart_wr  output  1  write strobe to uart_tx wr.
REQ-018 uart_buffempty  input  1  uart_tx buffempty, uart_clk domain, asynchronous to clk.

Function
REQ-019 uart_buffempty SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (be_s).
REQ-020 FSM states SHALL be IDLE, LOAD, WRITE, WAIT_LOW, WAIT_HIGH.
REQ-021 IDLE: if en=1 and any req bit set and be_s=1, select requester by round-robin starting at last_grant+1 modulo REQS, latch its data into uart_data, set grant_id, go LOAD.
REQ-022 IDLE with be_s=0 (uart still shifting) SHALL wait; no grant.
REQ-023 LOAD: one cycle data setup, uart_wr=0; next state WRITE with hold counter cleared.
REQ-024 WRITE: uart_wr=1 for exactly WR_HOLD cycles; on last cycle drive ack[grant_id]=1 for one cycle, go WAIT_LOW; uart_wr=0 from the following cycle.
REQ-025 WAIT_LOW: if be_s=0 go WAIT_HIGH; else increment 16-bit timeout counter; when counter reaches TIMEOUT set err=1, go IDLE.
REQ-026 WAIT_HIGH: when be_s=1 go IDLE and record last_grant=grant_id; no timeout in this state.
REQ-027 Round-robin SHALL guarantee each asserted requester a grant within REQS transfers.
REQ-028 Dropping req[i] before ack SHALL NOT abort a transfer already past IDLE; the latched character is still sent and ack still pulses.
REQ-029 en deasserted mid-transfer SHALL let the FSM complete to IDLE; it then stays in IDLE until en=1.
REQ-030 err_clr and a timeout in the same cycle: set wins (err=1).
REQ-031 At most one ack bit SHALL be high in any cycle; ack never asserts outside WRITE.
REQ-032 uart_data SHALL change only in IDLE-to-LOAD transition, so it is stable throughout uart_wr high and two cycles after.

Reset
REQ-033 rst=0 SHALL asynchronously force: state IDLE, uart_wr=0, ack=0, busy=0, err=0, uart_data=0, grant_id=REQS-1 (so requester 0 is first), timeout and hold counters 0, synchronizer flops 1.
REQ-034 Reset mid-transfer SHALL drop uart_wr within the reset assertion without waiting for clk; no ack issued for the aborted character.

Verification
REQ-035 Single request: req=0001, data_in[0]=0x047, be model drops 20 clk after wr -> uart_wr high 2 cycles starting 2 cycles after grant, uart_data=0x047, ack=0001 once, busy low after be returns.
REQ-036 Contention: req=1111 held, four distinct characters -> grant order 0,1,2,3,0; each ack exactly once per transfer.
REQ-037 Timeout: be held 1 permanently, TIMEOUT=255 -> err=1 at 255 cycles in WAIT_LOW, FSM returns IDLE; err_clr=1 -> err=0 next cycle.
REQ-038 en=0 during WRITE with req=0011 -> current transfer completes, no further grants until en=1, then requester 1 granted.
REQ-039 rst=0 asserted during WRITE -> uart_wr=0 immediately, ack never pulses, after release grant_id=REQS-1, busy=0.
REQ-040 be=0 at request time (uart busy) -> no grant until be_s=1, then normal transfer.
